bus_sequencer: RTL and testbench

- Owns the 16-cycle bus frame at 16 MHz that time-multiplexes the shared PET bus between FPGA-initiated accesses and the 6502.
- Sits directly upstream of the bus pins that the top-level sim harness checks for contention.
- Drives the FPGA-side tri-state enables, RAM strobes, cpu_be_o, cpu_ready_o and cpu_clk_o.
- Serves one FPGA access per frame via a req/done handshake from the SPI command path.

---
 rtl/bus_pkg.sv | 27 ++
 rtl/frame_counter.sv | 33 +++
 rtl/bus_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_bus_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared frame timing constants and request payload for the PET bus sequencer.
package bus_pkg;

   localparam int unsigned BUS_ADDR_W = 17;
   localparam int unsigned BUS_DATA_W = 8;
   localparam int unsigned CYCLE_W    = 4;
   localparam int unsigned FRAME_LEN  = 16;

   // Frame cycle map (cycle numbers within the 16-cycle frame)
   localparam int unsigned GUARD_END        = 1;
   localparam int unsigned FPGA_ADDR_START  = 2;
   localparam int unsigned FPGA_WR_START    = 3;
   localparam int unsigned RAM_STROBE_START = 4;
   localparam int unsigned RAM_WE_END       = 5;
   localparam int unsigned FPGA_END         = 6;
   localparam int unsigned DONE             = 7;
   localparam int unsigned CPU_START        = 8;
   localparam int unsigned PHI2_START       = 12;
   localparam int unsigned FRAME_LAST       = 15;

   typedef struct packed {
      logic                  we;
      logic [BUS_ADDR_W-1:0] addr;
      logic [BUS_DATA_W-1:0] data;
   } bus_req_t;

endpackage

// File: rtl/frame_counter.sv
// 4-bit frame position counter with a one-hot decode of the upcoming cycle,
// so the sequencer can register outputs that line up with the counter value.
module frame_counter
   import bus_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_reset,
   output logic [CYCLE_W-1:0]   o_cycle,
   output logic [FRAME_LEN-1:0] o_hot_nxt
);

   logic [CYCLE_W-1:0] r_cycle;
   logic [CYCLE_W-1:0] w_cycle_nxt;

   always_comb begin
      w_cycle_nxt = r_cycle + CYCLE_W'(1);
      if (r_cycle == CYCLE_W'(FRAME_LAST)) begin
         w_cycle_nxt = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cycle <= '0;
      end else begin
         r_cycle <= w_cycle_nxt;
      end
   end

   assign o_cycle   = r_cycle;
   assign o_hot_nxt = FRAME_LEN'(1) << w_cycle_nxt;

endmodule

// File: rtl/bus_sequencer.sv
// Time-multiplexes the shared PET bus: one FPGA access in cycles 2-7 of each
// 16-cycle frame, the 6502 owns cycles 8-15. All outputs are registered.
module bus_sequencer
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = BUS_ADDR_W,
   parameter int unsigned DATA_WIDTH = BUS_DATA_W
) (
   input  logic                  clk16_i,
   input  logic                  reset_i,
   input  logic                  fpga_req_i,
   input  logic                  fpga_we_i,
   input  logic [ADDR_WIDTH-1:0] fpga_addr_i,
   input  logic [DATA_WIDTH-1:0] fpga_wr_data_i,
   output logic [DATA_WIDTH-1:0] fpga_rd_data_o,
   output logic                  fpga_done_o,
   input  logic                  cpu_stop_i,
   input  logic [DATA_WIDTH-1:0] bus_data_i,
   input  logic                  bus_rw_ni,
   input  logic                  cpu_ram_sel_i,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic                  bus_addr_oe,
   output logic [DATA_WIDTH-1:0] bus_data_o,
   output logic                  bus_data_oe,
   output logic                  bus_rw_no,
   output logic                  bus_rw_noe,
   output logic                  ram_oe_no,
   output logic                  ram_we_no,
   output logic                  cpu_be_o,
   output logic                  cpu_ready_o,
   output logic                  cpu_clk_o
);

   logic [CYCLE_W-1:0]   w_cycle;
   logic [FRAME_LEN-1:0] w_hot;

   frame_counter u_frame_counter (
      .i_clk     (clk16_i),
      .i_reset   (reset_i),
      .o_cycle   (w_cycle),
      .o_hot_nxt (w_hot)
   );

   bus_req_t            r_req;
   logic                r_active;
   logic                r_stop;
   logic [ADDR_WIDTH-1:0] r_bus_addr;
   logic [DATA_WIDTH-1:0] r_bus_data;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic r_addr_oe, r_data_oe, r_rw_noe, r_rw_n;
   logic r_ram_oe_n, r_ram_we_n, r_cpu_be, r_cpu_rdy, r_cpu_clk, r_done;

   logic [ADDR_WIDTH-1:0] w_bus_addr;
   logic [DATA_WIDTH-1:0] w_bus_data;
   logic w_addr_oe, w_data_oe, w_rw_noe, w_rw_n;
   logic w_ram_oe_n, w_ram_we_n, w_cpu_be, w_cpu_rdy, w_cpu_clk, w_done;
   logic w_win_addr, w_win_wr, w_win_we, w_win_rd, w_win_cpu, w_win_phi2;

   // Windows are decoded for the cycle the registered outputs will belong to
   assign w_win_addr = |w_hot[FPGA_END:FPGA_ADDR_START];
   assign w_win_wr   = |w_hot[FPGA_END:FPGA_WR_START];
   assign w_win_we   = |w_hot[RAM_WE_END:RAM_STROBE_START];
   assign w_win_rd   = |w_hot[FPGA_END:RAM_STROBE_START];
   assign w_win_cpu  = |w_hot[FRAME_LAST:CPU_START];
   assign w_win_phi2 = |w_hot[FRAME_LAST:PHI2_START];

   always_comb begin
      w_addr_oe  = 1'b0;
      w_data_oe  = 1'b0;
      w_rw_noe   = 1'b0;
      w_rw_n     = 1'b1;
      w_ram_oe_n = 1'b1;
      w_ram_we_n = 1'b1;
      w_cpu_be   = 1'b0;
      w_cpu_rdy  = 1'b0;
      w_cpu_clk  = 1'b0;
      w_done     = 1'b0;
      w_bus_addr = r_bus_addr;
      w_bus_data = r_bus_data;

      if (r_active && w_win_addr) begin
         w_addr_oe  = 1'b1;
         w_rw_noe   = 1'b1;
         w_rw_n     = ~r_req.we;
         w_bus_addr = r_req.addr;
         if (r_req.we) begin
            if (w_win_wr) begin
               w_data_oe  = 1'b1;
               w_bus_data = r_req.data;
            end
            if (w_win_we) begin
               w_ram_we_n = 1'b0;
            end
         end else if (w_win_rd) begin
            w_ram_oe_n = 1'b0;
         end
      end

      if (r_active && w_hot[DONE]) begin
         w_done = 1'b1;
      end

      if (w_win_cpu) begin
         w_cpu_be  = ~r_stop;
         w_cpu_rdy = ~r_stop;
      end

      // CPU RAM strobes ride on PHI2 and only for a granted, RAM-decoded cycle
      if (w_win_phi2) begin
         w_cpu_clk = 1'b1;
         if (!r_stop && cpu_ram_sel_i) begin
            if (bus_rw_ni) begin
               w_ram_oe_n = 1'b0;
            end else begin
               w_ram_we_n = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk16_i) begin
      if (reset_i) begin
         r_req      <= '0;
         r_active   <= 1'b0;
         r_stop     <= 1'b1;
         r_rd_data  <= '0;
         r_bus_addr <= '0;
         r_bus_data <= '0;
         r_addr_oe  <= 1'b0;
         r_data_oe  <= 1'b0;
         r_rw_noe   <= 1'b0;
         r_rw_n     <= 1'b1;
         r_ram_oe_n <= 1'b1;
         r_ram_we_n <= 1'b1;
         r_cpu_be   <= 1'b0;
         r_cpu_rdy  <= 1'b0;
         r_cpu_clk  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         if (w_cycle == '0) begin
            r_stop <= cpu_stop_i;
            if (fpga_req_i) begin
               r_active   <= 1'b1;
               r_req.we   <= fpga_we_i;
               r_req.addr <= fpga_addr_i;
               r_req.data <= fpga_wr_data_i;
            end
         end else if (w_cycle == CYCLE_W'(DONE)) begin
            r_active <= 1'b0;
         end

         if (r_active && !r_req.we && (w_cycle == CYCLE_W'(FPGA_END))) begin
            r_rd_data <= bus_data_i;
         end

         r_bus_addr <= w_bus_addr;
         r_bus_data <= w_bus_data;
         r_addr_oe  <= w_addr_oe;
         r_data_oe  <= w_data_oe;
         r_rw_noe   <= w_rw_noe;
         r_rw_n     <= w_rw_n;
         r_ram_oe_n <= w_ram_oe_n;
         r_ram_we_n <= w_ram_we_n;
         r_cpu_be   <= w_cpu_be;
         r_cpu_rdy  <= w_cpu_rdy;
         r_cpu_clk  <= w_cpu_clk;
         r_done     <= w_done;
      end
   end

   assign fpga_rd_data_o = r_rd_data;
   assign fpga_done_o    = r_done;
   assign bus_addr_o     = r_bus_addr;
   assign bus_addr_oe    = r_addr_oe;
   assign bus_data_o     = r_bus_data;
   assign bus_data_oe    = r_data_oe;
   assign bus_rw_no      = r_rw_n;
   assign bus_rw_noe     = r_rw_noe;
   assign ram_oe_no      = r_ram_oe_n;
   assign ram_we_no      = r_ram_we_n;
   assign cpu_be_o       = r_cpu_be;
   assign cpu_ready_o    = r_cpu_rdy;
   assign cpu_clk_o      = r_cpu_clk;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: directed frame scenarios then random traffic, all
// checked cycle by cycle against a frame-position reference model.
module tb_bus_sequencer;

   logic        clk16_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        fpga_req_i = 1'b0;
   logic        fpga_we_i = 1'b0;
   logic [16:0] fpga_addr_i = '0;
   logic [7:0]  fpga_wr_data_i = '0;
   logic [7:0]  fpga_rd_data_o;
   logic        fpga_done_o;
   logic        cpu_stop_i = 1'b0;
   logic [7:0]  bus_data_i = '0;
   logic        bus_rw_ni = 1'b1;
   logic        cpu_ram_sel_i = 1'b0;
   logic [16:0] bus_addr_o;
   logic        bus_addr_oe;
   logic [7:0]  bus_data_o;
   logic        bus_data_oe;
   logic        bus_rw_no;
   logic        bus_rw_noe;
   logic        ram_oe_no;
   logic        ram_we_no;
   logic        cpu_be_o;
   logic        cpu_ready_o;
   logic        cpu_clk_o;

   always #5 clk16_i = ~clk16_i;

   bus_sequencer dut (
      .clk16_i        (clk16_i),
      .reset_i        (reset_i),
      .fpga_req_i     (fpga_req_i),
      .fpga_we_i      (fpga_we_i),
      .fpga_addr_i    (fpga_addr_i),
      .fpga_wr_data_i (fpga_wr_data_i),
      .fpga_rd_data_o (fpga_rd_data_o),
      .fpga_done_o    (fpga_done_o),
      .cpu_stop_i     (cpu_stop_i),
      .bus_data_i     (bus_data_i),
      .bus_rw_ni      (bus_rw_ni),
      .cpu_ram_sel_i  (cpu_ram_sel_i),
      .bus_addr_o     (bus_addr_o),
      .bus_addr_oe    (bus_addr_oe),
      .bus_data_o     (bus_data_o),
      .bus_data_oe    (bus_data_oe),
      .bus_rw_no      (bus_rw_no),
      .bus_rw_noe     (bus_rw_noe),
      .ram_oe_no      (ram_oe_no),
      .ram_we_no      (ram_we_no),
      .cpu_be_o       (cpu_be_o),
      .cpu_ready_o    (cpu_ready_o),
      .cpu_clk_o      (cpu_clk_o)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned issued = 0;
   int unsigned obs_done = 0;

   // Reference model: frame position plus the access captured at position 0
   int          m = 0;
   bit          act = 0, stop_m = 1, l_we = 0;
   logic [16:0] l_addr = '0;
   logic [7:0]  l_data = '0;
   bit          e_addr_oe, e_data_oe, e_rw_noe, e_rw_n;
   bit          e_oe_n, e_we_n, e_be, e_rdy, e_clk, e_done;
   logic [7:0]  e_rd = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (frame pos %0d, t=%0t)", tag, obs, exp, m, $time);
      end
   endtask

   task automatic model_edge();
      int prev;
      e_addr_oe = 0; e_data_oe = 0; e_rw_noe = 0; e_rw_n = 1;
      e_oe_n = 1; e_we_n = 1; e_be = 0; e_rdy = 0; e_clk = 0; e_done = 0;
      if (reset_i) begin
         m = 0; act = 0; stop_m = 1; e_rd = '0;
      end else begin
         prev = m;
         if (prev == 0) begin
            stop_m = cpu_stop_i;
            if (fpga_req_i) begin
               act = 1; l_we = fpga_we_i; l_addr = fpga_addr_i; l_data = fpga_wr_data_i;
            end
         end
         if (prev == 6 && act && !l_we) e_rd = bus_data_i;
         m = (prev + 1) % 16;
         if (act && m >= 2 && m <= 6) begin
            e_addr_oe = 1; e_rw_noe = 1; e_rw_n = !l_we;
            e_data_oe = l_we && m >= 3;
            e_we_n = !(l_we && (m == 4 || m == 5));
            e_oe_n = !(!l_we && m >= 4);
         end
         e_done = act && m == 7;
         if (m >= 8) begin
            e_be = !stop_m; e_rdy = !stop_m;
         end
         if (m >= 12) begin
            e_clk = 1;
            if (!stop_m && cpu_ram_sel_i) begin
               if (bus_rw_ni) e_oe_n = 0;
               else e_we_n = 0;
            end
         end
         if (prev == 7) act = 0;
      end
   endtask

   task automatic compare();
      check("enables", {bus_addr_oe, bus_data_oe, bus_rw_noe}, {e_addr_oe, e_data_oe, e_rw_noe});
      check("rw_n", bus_rw_no, e_rw_n);
      check("ram_strobes", {ram_oe_no, ram_we_no}, {e_oe_n, e_we_n});
      check("cpu_ctl", {cpu_be_o, cpu_ready_o, cpu_clk_o}, {e_be, e_rdy, e_clk});
      check("done", fpga_done_o, e_done);
      check("rd_data", fpga_rd_data_o, e_rd);
      check("oe_vs_be", (bus_addr_oe | bus_data_oe | bus_rw_noe) & cpu_be_o, 0);
      if (e_addr_oe) check("bus_addr", bus_addr_o, l_addr);
      if (e_data_oe) check("bus_data", bus_data_o, l_data);
   endtask

   // One clock: model tracks the edge, outputs sampled 1 time unit later
   task automatic step();
      @(posedge clk16_i);
      model_edge();
      #1;
      compare();
      if (fpga_done_o) obs_done++;
      if (fpga_req_i && e_done) fpga_req_i = 1'b0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic start_req(input logic we, input logic [16:0] addr, input logic [7:0] data);
      fpga_req_i = 1'b1; fpga_we_i = we; fpga_addr_i = addr; fpga_wr_data_i = data;
      issued++;
   endtask

   initial begin
      // Reset held three cycles, then idle outputs
      steps(3);
      reset_i = 1'b0;
      check("reset_done_cnt", obs_done, 0);

      // Write issued before cycle 0
      start_req(1'b1, 17'h08000, 8'hA5);
      steps(16);
      check("wr_done_cnt", obs_done, 1);

      // Read with bus data driven during cycle 6
      start_req(1'b0, 17'h1FFFF, 8'h00);
      steps(6);
      bus_data_i = 8'h3C;
      step();
      check("rd_dir_data", fpga_rd_data_o, 8'h3C);
      check("rd_dir_done", fpga_done_o, 1);
      bus_data_i = 8'h00;
      steps(9);

      // Request first raised at cycle 1 waits for the next frame
      step();
      start_req(1'b1, 17'h00123, 8'h5A);
      steps(15);
      check("late_no_done", obs_done, 2);
      steps(16);
      check("late_done_cnt", obs_done, 3);

      // Stopped CPU, then released with RAM decoded
      cpu_stop_i = 1'b1; cpu_ram_sel_i = 1'b1; bus_rw_ni = 1'b0;
      steps(16);
      cpu_stop_i = 1'b0;
      steps(16);
      bus_rw_ni = 1'b1;
      steps(16);

      // Reset at cycle 4 of a write; request held and served after reset
      start_req(1'b1, 17'h0ABCD, 8'hC3);
      steps(4);
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      check("rst_abort_cnt", obs_done, 3);
      steps(16);
      check("rst_served_cnt", obs_done, 4);

      // Random traffic
      for (int c = 0; c < 3000 * 16; c++) begin
         if (!fpga_req_i && $urandom_range(0, 7) == 0)
            start_req(1'($urandom), 17'($urandom), 8'($urandom));
         if ($urandom_range(0, 31) == 0) cpu_stop_i = ~cpu_stop_i;
         bus_data_i    = 8'($urandom);
         bus_rw_ni     = 1'($urandom);
         cpu_ram_sel_i = 1'($urandom);
         reset_i       = ($urandom_range(0, 399) == 0);
         step();
      end
      reset_i = 1'b0;
      for (int c = 0; c < 20 && m != 0; c++) step();
      check("end_at_frame_start", 32'(m), 0);
      check("done_per_request", obs_done, issued - 32'(fpga_req_i));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
